// File: rtl/dcm_phase_seq.sv
// rtl/dcm_phase_seq.sv - Phase-shift sequencer issuing single PSEN/PSINCDEC steps to the SDRAM clock DCM wrapper
//
// Purpose:
//   Software writes an absolute target phase, or nudges it by +/-1. The
//   sequencer walks the DCM one step at a time towards that target. Each step
//   is paced by the wrapper's dcm_done ready flag and followed by a settle gap.
//   The block tracks the current phase offset, which is 0 after DCM reset.
//   Targets are clamped to [-PH_MAX, +PH_MAX].
//
// Ports:
//   dcm_clk     in   phase-shift clock (also the wrapper's PSCLK)
//   dcm_rst     in   asynchronous active-high reset (also the DCM reset)
//   locked      in   DCM locked, asynchronous; synchronised internally
//   dcm_done    in   wrapper ready flag; low while a step is in flight
//   tgt_wr      in   load tgt_data as the new absolute target
//   tgt_data    in   signed absolute target, PH_W bits
//   step_inc    in   target += 1 (saturating)
//   step_dec    in   target -= 1 (saturating)
//   dcm_en      out  single-cycle PSEN pulse
//   dcm_incdec  out  step direction, 1 = increment, valid with dcm_en
//   cur_phase   out  signed current DCM phase
//   tgt_phase   out  signed clamped target
//   busy        out  stepping in progress or cur_phase != tgt_phase
//   clamped     out  sticky: a request fell outside +/-PH_MAX
//   ps_timeout  out  sticky: dcm_done never returned (optional feature)
//
// Optional feature: define DCM_PHASE_SEQ_TIMEOUT_EN to abort a step whose
// dcm_done does not return within TIMEOUT cycles. Without it, WAIT waits
// indefinitely and ps_timeout is constant 0.

module dcm_phase_seq #(
  parameter int PH_W    = 9,
  parameter int PH_MAX  = 255,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   dcm_clk,
  input  logic                   dcm_rst,
  input  logic                   locked,
  input  logic                   dcm_done,
  input  logic                   tgt_wr,
  input  logic signed [PH_W-1:0] tgt_data,
  input  logic                   step_inc,
  input  logic                   step_dec,
  output logic                   dcm_en,
  output logic                   dcm_incdec,
  output logic signed [PH_W-1:0] cur_phase,
  output logic signed [PH_W-1:0] tgt_phase,
  output logic                   busy,
  output logic                   clamped,
  output logic                   ps_timeout
);

  localparam logic signed [PH_W-1:0] P_MAX    = PH_W'(PH_MAX);
  localparam logic signed [PH_W-1:0] P_MIN    = -P_MAX;
  localparam logic signed [PH_W-1:0] P_ONE    = PH_W'(1);
  localparam logic        [3:0]      SETTLE_V = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t     state, state_nx;
  logic       lock_q, lock_s;
  logic [3:0] settle_cnt;
  logic       dir_q;
  logic       step_done;
  logic       wr_over, wr_under;

  // Two-flop synchroniser for the asynchronous locked flag
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) begin
      lock_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_q <= locked;
      lock_s <= lock_q;
    end
  end

  assign wr_over  = (tgt_data > P_MAX);
  assign wr_under = (tgt_data < P_MIN);

  // Target register; tgt_wr restarts the clamped history before judging
  // the new value, step_inc together with step_dec cancel each other.
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) begin
      tgt_phase <= '0;
      clamped   <= 1'b0;
    end else if (tgt_wr) begin
      clamped <= wr_over | wr_under;
      if (wr_over)       tgt_phase <= P_MAX;
      else if (wr_under) tgt_phase <= P_MIN;
      else               tgt_phase <= tgt_data;
    end else if (step_inc && !step_dec) begin
      if (tgt_phase >= P_MAX) clamped   <= 1'b1;
      else                    tgt_phase <= tgt_phase + P_ONE;
    end else if (step_dec && !step_inc) begin
      if (tgt_phase <= P_MIN) clamped   <= 1'b1;
      else                    tgt_phase <= tgt_phase - P_ONE;
    end
  end

`ifdef DCM_PHASE_SEQ_TIMEOUT_EN
  localparam int             TO_W   = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;
  logic            to_fire;

  // Counts cycles spent waiting for the wrapper after a PSEN
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst)                                 to_cnt <= '0;
    else if (state == S_GUARD || state == S_WAIT) to_cnt <= to_cnt + 1'b1;
    else                                         to_cnt <= '0;
  end

  assign to_fire = (state == S_WAIT) && !dcm_done && (to_cnt >= TO_LIM);

  // A timeout raised in the same cycle as tgt_wr wins so it is never lost
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst)      ps_timeout <= 1'b0;
    else if (to_fire) ps_timeout <= 1'b1;
    else if (tgt_wr)  ps_timeout <= 1'b0;
  end
`else
  // Constant 0; TIMEOUT only sizes the abort counter of the optional feature
  assign ps_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    dcm_en     = 1'b0;
    dcm_incdec = 1'b0;
    step_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (lock_s && dcm_done && (settle_cnt == 4'd0) && !ps_timeout &&
            (cur_phase != tgt_phase))
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        dcm_en     = 1'b1;
        dcm_incdec = (tgt_phase > cur_phase);
        state_nx   = S_GUARD;
      end
      // The wrapper's registered done flag is still high in this cycle
      S_GUARD: state_nx = S_WAIT;
      S_WAIT: begin
        if (dcm_done) begin
          step_done = 1'b1;
          state_nx  = S_IDLE;
        end
`ifdef DCM_PHASE_SEQ_TIMEOUT_EN
        else if (to_fire) begin
          state_nx = S_IDLE;
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Direction is frozen at ISSUE so a target reversal mid-step cannot
  // corrupt the phase bookkeeping of the step already in flight.
  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) begin
      dir_q      <= 1'b0;
      cur_phase  <= '0;
      settle_cnt <= 4'd0;
    end else begin
      if (state == S_ISSUE) dir_q <= dcm_incdec;
      if (step_done) begin
        cur_phase  <= dir_q ? (cur_phase + P_ONE) : (cur_phase - P_ONE);
        settle_cnt <= SETTLE_V;
      end else if (state == S_IDLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  assign busy = (state != S_IDLE) || (cur_phase != tgt_phase);

endmodule

// File: tb/tb_dcm_phase_seq.sv
// tb/tb_dcm_phase_seq.sv - Scoreboard bench for dcm_phase_seq with a PSDONE responder model

module tb_dcm_phase_seq;

  localparam int PH_W   = 10;
  localparam int SETTLE = 4;
  localparam int LAT    = 5;

  logic                   dcm_clk = 1'b0;
  logic                   dcm_rst, locked, dcm_done, tgt_wr, step_inc, step_dec;
  logic signed [PH_W-1:0] tgt_data;
  logic                   dcm_en, dcm_incdec, busy, clamped, ps_timeout;
  logic signed [PH_W-1:0] cur_phase, tgt_phase;

  dcm_phase_seq #(.PH_W(PH_W), .PH_MAX(255), .SETTLE(SETTLE), .TIMEOUT(1023)) dut (
    .dcm_clk(dcm_clk), .dcm_rst(dcm_rst), .locked(locked), .dcm_done(dcm_done),
    .tgt_wr(tgt_wr), .tgt_data(tgt_data), .step_inc(step_inc), .step_dec(step_dec),
    .dcm_en(dcm_en), .dcm_incdec(dcm_incdec), .cur_phase(cur_phase), .tgt_phase(tgt_phase),
    .busy(busy), .clamped(clamped), .ps_timeout(ps_timeout)
  );

  always #5 dcm_clk = ~dcm_clk;

  int cyc = 0;
  always @(posedge dcm_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int incdec;
    int cur;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_exp(input int d, input int c);
    exp_t e;
    e.incdec = d;
    e.cur    = c;
    exp_q.push_back(e);
  endfunction

  // PSDONE responder: done drops after each PSEN and returns LAT cycles later
  bit hold_done = 1'b0;
  int done_cnt  = 0;
  initial begin
    dcm_done = 1'b1;
    forever begin
      @(negedge dcm_clk);
      if (dcm_rst) begin
        dcm_done = 1'b1;
        done_cnt = 0;
      end else if (dcm_en) begin
        dcm_done = 1'b0;
        done_cnt = LAT + 1;
      end else if (!hold_done && done_cnt > 0) begin
        if (done_cnt <= 1) begin
          done_cnt = 0;
          dcm_done = 1'b1;
        end else begin
          done_cnt--;
        end
      end
    end
  end

  // Monitor: every PSEN pulse is matched against the next expected step
  int en_count  = 0;
  bit chk_space = 1'b0;
  initial begin
    bit   prev_en    = 1'b0;
    bit   prev_armed = 1'b0;
    int   last_en    = 0;
    exp_t e;
    forever begin
      @(negedge dcm_clk);
      if (!dcm_rst && dcm_en) begin
        en_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_en: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("en_incdec", int'(dcm_incdec), e.incdec);
          check("en_cur_phase", int'(cur_phase), e.cur);
        end
        check("en_not_back_to_back", int'(prev_en), 0);
        if (chk_space && prev_armed)
          check("en_spacing_ge_12", int'((cyc - last_en) >= 3 + LAT + SETTLE), 1);
        prev_armed = chk_space;
        last_en    = cyc;
      end
      prev_en = dcm_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge dcm_clk);
  endtask

  task automatic write_tgt(input int v);
    tgt_wr   = 1'b1;
    tgt_data = PH_W'(v);
    tick(1);
    tgt_wr   = 1'b0;
  endtask

  task automatic pulse_step(input bit inc, input bit dec);
    step_inc = inc;
    step_dec = dec;
    tick(1);
    step_inc = 1'b0;
    step_dec = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_en(input int bound, output int at);
    int n = 0;
    at = -1;
    while (n < bound && at < 0) begin
      if (dcm_en) at = cyc;
      else begin
        tick(1);
        n++;
      end
    end
    check("en_seen", int'(at >= 0), 1);
  endtask

  task automatic check_reset_vals();
    check("rst_dcm_en", int'(dcm_en), 0);
    check("rst_incdec", int'(dcm_incdec), 0);
    check("rst_cur_phase", int'(cur_phase), 0);
    check("rst_tgt_phase", int'(tgt_phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clamped", int'(clamped), 0);
    check("rst_ps_timeout", int'(ps_timeout), 0);
  endtask

  initial begin
    int at, ref_cyc, snap;
    dcm_rst  = 1'b1;
    locked   = 1'b1;
    tgt_wr   = 1'b0;
    tgt_data = '0;
    step_inc = 1'b0;
    step_dec = 1'b0;
    tick(3);
    check_reset_vals();
    dcm_rst = 1'b0;
    tick(4);

    // Three increments from phase 0
    push_exp(1, 0); push_exp(1, 1); push_exp(1, 2);
    ref_cyc = cyc;
    write_tgt(3);
    wait_en(10, at);
    check("first_en_latency", at - ref_cyc, 2);
    wait_idle(200);
    tick(SETTLE);
    check("t1_cur_phase", int'(cur_phase), 3);
    check("t1_busy_after_settle", int'(busy), 0);
    check("t1_pending", exp_q.size(), 0);

    // Five decrements down to -2, spacing checked by the monitor
    chk_space = 1'b1;
    push_exp(0, 3); push_exp(0, 2); push_exp(0, 1); push_exp(0, 0); push_exp(0, -1);
    write_tgt(-2);
    wait_idle(300);
    chk_space = 1'b0;
    check("t2_cur_phase", int'(cur_phase), -2);
    check("t2_pending", exp_q.size(), 0);

    // Clamp behaviour with stepping held off by locked=0
    locked = 1'b0;
    tick(4);
    write_tgt(300);
    check("clamp_hi_tgt", int'(tgt_phase), 255);
    check("clamp_hi_flag", int'(clamped), 1);
    pulse_step(1, 0);
    check("inc_at_max_tgt", int'(tgt_phase), 255);
    check("inc_at_max_flag", int'(clamped), 1);
    pulse_step(0, 1);
    check("dec_from_max_tgt", int'(tgt_phase), 254);
    check("clamped_sticky", int'(clamped), 1);
    write_tgt(10);
    check("wr_clears_tgt", int'(tgt_phase), 10);
    check("wr_clears_clamped", int'(clamped), 0);
    pulse_step(1, 1);
    check("inc_dec_same_cycle", int'(tgt_phase), 10);
    pulse_step(1, 0);
    check("inc_normal", int'(tgt_phase), 11);
    write_tgt(-300);
    check("clamp_lo_tgt", int'(tgt_phase), -255);
    check("clamp_lo_flag", int'(clamped), 1);
    write_tgt(4);
    pulse_step(0, 1);
    check("dec_normal", int'(tgt_phase), 3);
    write_tgt(4);
    check("t3_clamped_clear", int'(clamped), 0);

    // Unlocked: no stepping; lock rise starts stepping 3 cycles later
    snap = en_count;
    tick(20);
    check("no_en_while_unlocked", en_count, snap);
    push_exp(1, -2);
    ref_cyc = cyc;
    locked  = 1'b1;
    wait_en(10, at);
    check("lock_to_en_latency", at - ref_cyc, 3);
    tick(2);
    locked = 1'b0;
    tick(10);
    check("t4_step_completed", int'(cur_phase), -1);
    check("t4_busy", int'(busy), 1);
    tick(30);
    check("t4_single_pulse", en_count, snap + 1);
    check("t4_pending", exp_q.size(), 0);

    // Reset asserted while waiting on the step leaving phase 7
    for (int p = -1; p <= 7; p++) push_exp(1, p);
    locked = 1'b1;
    write_tgt(9);
    at = 0;
    while (at < 400 && !(dcm_en && cur_phase == 7)) begin
      tick(1);
      at++;
    end
    check("t5_reached_7", int'(cur_phase), 7);
    tick(2);
    dcm_rst = 1'b1;
    #1;
    check_reset_vals();
    check("t5_pending", exp_q.size(), 0);
    tick(2);
    dcm_rst = 1'b0;
    snap = en_count;
    tick(40);
    check("t5_no_en_after_rst", en_count, snap);
    check("t5_cur_phase", int'(cur_phase), 0);
    check("t5_busy", int'(busy), 0);

`ifdef DCM_PHASE_SEQ_TIMEOUT_EN
    // dcm_done never returns: abort, hold phase, inhibit until tgt_wr
    hold_done = 1'b1;
    snap = en_count;
    push_exp(1, 0);
    write_tgt(2);
    at = 0;
    while (!ps_timeout && at < 1200) begin
      tick(1);
      at++;
    end
    check("to_flag_set", int'(ps_timeout), 1);
    check("to_wait_ge_timeout", int'(at >= 1023), 1);
    check("to_cur_unchanged", int'(cur_phase), 0);
    tick(30);
    check("to_no_more_en", en_count, snap + 1);
    hold_done = 1'b0;
    tick(5);
    push_exp(1, 0); push_exp(1, 1);
    write_tgt(2);
    check("to_cleared_by_wr", int'(ps_timeout), 0);
    tick(1);
    wait_idle(200);
    check("to_resume_cur", int'(cur_phase), 2);
`endif

    tick(5);
    check("final_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
